sevseg_capture: RTL and testbench

//  Receive-side counterpart of the 4-digit seven-segment display driver.
//  - Samples the time-multiplexed an/seg/dp bus.
//  - Filters out transitional and ghost patterns.
//  - Decodes each settled segment pattern back to a hex nibble.
//  - Publishes a complete 4-digit frame with a one-cycle valid strobe.

---
 rtl/sevseg_pkg.sv | 49 ++++
 rtl/sevseg_decode.sv | 24 ++
 rtl/sevseg_capture.sv | 177 +++++++++++++++++
 tb/tb_sevseg_capture.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment display encoder and capture monitor.
// Holds the segment pattern table (active-low, bit 0 = a ... bit 6 = g), the
// capture FSM state type and small anode-select helpers.
package sevseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index n holds the active-low pattern that displays hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,  // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

  typedef enum logic [1:0] {
    StWait,
    StQual,
    StCommit,
    StHeld
  } state_e;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } bus_t;

  localparam bus_t BUS_IDLE = '{an: 4'hF, seg: SEG_BLANK, dp: 1'b1};

  // True when exactly one anode is driven low.
  function automatic logic sel_valid(input logic [3:0] an);
    case (an)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Digit position of the single low anode; only meaningful when sel_valid().
  function automatic logic [1:0] sel_index(input logic [3:0] an);
    case (an)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sevseg_decode.sv
// Combinational seven-segment pattern decoder.
//   seg_i    : active-low segment pattern, bit 0 = a ... bit 6 = g
//   nibble_o : hex value of the pattern (0 when not recognised)
//   err_o    : pattern is not one of the 16 hex glyphs
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       err_o
);

  always_comb begin
    nibble_o = 4'd0;
    err_o    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_TABLE[i]) begin
        nibble_o = 4'(i);
        err_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sevseg_capture.sv
// Seven-segment bus capture monitor.
// Samples a time-multiplexed 4-digit an/seg/dp bus, waits for each digit select
// to settle for STABLE_CYCLES samples, decodes it and publishes complete frames.
//   clk, reset     : clock, synchronous active-high reset
//   an, seg, dp    : display bus, all active-low
//   digit0..3      : captured hex value per digit (an[0] -> digit0)
//   dp_out         : captured decimal points, active-high
//   frame_valid    : one-cycle strobe, frame outputs just updated
//   frame_err      : last frame held at least one undecodable pattern
//   blank          : no valid select seen for TIMEOUT_CYCLES
module sevseg_capture
  import sevseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  input  logic       dp,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dp_out,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       blank
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

  bus_t                 in_q, prev_q;
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [3:0]           mask_q, mask_d;
  logic [3:0][3:0]      stage_q, stage_d;
  logic [3:0]           stage_dp_q, stage_dp_d;
  logic                 stage_err_q, stage_err_d;
  logic [3:0][3:0]      digit_q, digit_d;
  logic [3:0]           dp_out_q, dp_out_d;
  logic                 frame_err_q, frame_err_d;
  logic                 frame_valid_q, frame_valid_d;

  logic                 in_valid, changed;
  logic [1:0]           commit_idx;
  logic [3:0]           dec_nibble;
  logic                 dec_err;

  // In COMMIT, prev_q still holds the last sample of the stable run, even if
  // the bus has already moved on in in_q.
  sevseg_decode u_decode (
    .seg_i    (prev_q.seg),
    .nibble_o (dec_nibble),
    .err_o    (dec_err)
  );

  assign in_valid   = sel_valid(in_q.an);
  assign changed    = (in_q != prev_q);
  assign commit_idx = sel_index(prev_q.an);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tcnt_d        = tcnt_q;
    mask_d        = mask_q;
    stage_d       = stage_q;
    stage_dp_d    = stage_dp_q;
    stage_err_d   = stage_err_q;
    digit_d       = digit_q;
    dp_out_d      = dp_out_q;
    frame_err_d   = frame_err_q;
    frame_valid_d = 1'b0;

    case (state_q)
      StWait: begin
        if (in_valid) begin
          state_d = StQual;
          cnt_d   = CntW'(1);
        end
      end
      StQual: begin
        if (changed) begin
          if (in_valid) cnt_d = CntW'(1);
          else          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntW'(STABLE_CYCLES)) state_d = StCommit;
        end
      end
      StCommit, StHeld: begin
        // A change during the COMMIT cycle is handled here too so it is not lost.
        if (changed) begin
          if (in_valid) begin
            state_d = StQual;
            cnt_d   = CntW'(1);
          end else begin
            state_d = StWait;
          end
        end else begin
          state_d = StHeld;
        end
      end
      default: state_d = StWait;
    endcase

    // Frame emission runs first so a commit in the same cycle would land in a
    // fresh frame rather than be wiped.
    if (mask_q == 4'hF) begin
      digit_d       = stage_q;
      dp_out_d      = stage_dp_q;
      frame_err_d   = stage_err_q;
      frame_valid_d = 1'b1;
      mask_d        = 4'h0;
      stage_err_d   = 1'b0;
    end

    if (state_q == StCommit) begin
      stage_d[commit_idx]    = dec_nibble;
      stage_dp_d[commit_idx] = ~prev_q.dp;
      stage_err_d            = stage_err_d | dec_err;
      mask_d[commit_idx]     = 1'b1;
    end

    if (in_valid) begin
      tcnt_d = '0;
    end else if (state_q == StWait && tcnt_q != TW'(TIMEOUT_CYCLES)) begin
      tcnt_d = tcnt_q + 1'b1;
      if (tcnt_d == TW'(TIMEOUT_CYCLES)) mask_d = 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q          <= BUS_IDLE;
      prev_q        <= BUS_IDLE;
      state_q       <= StWait;
      cnt_q         <= '0;
      tcnt_q        <= '0;
      mask_q        <= '0;
      stage_q       <= '0;
      stage_dp_q    <= '0;
      stage_err_q   <= 1'b0;
      digit_q       <= '0;
      dp_out_q      <= '0;
      frame_err_q   <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      in_q          <= '{an: an, seg: seg, dp: dp};
      prev_q        <= in_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tcnt_q        <= tcnt_d;
      mask_q        <= mask_d;
      stage_q       <= stage_d;
      stage_dp_q    <= stage_dp_d;
      stage_err_q   <= stage_err_d;
      digit_q       <= digit_d;
      dp_out_q      <= dp_out_d;
      frame_err_q   <= frame_err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign digit3      = digit_q[3];
  assign dp_out      = dp_out_q;
  assign frame_err   = frame_err_q;
  assign frame_valid = frame_valid_q;
  assign blank       = (tcnt_q == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_sevseg_capture.sv
// Testbench for sevseg_capture: directed sequences, a table of glyph vectors and
// randomized bus traffic checked against an input-level behavioural model.
module tb_sevseg_capture;

  localparam int unsigned STABLE  = 4;
  localparam int unsigned TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] digit0, digit1, digit2, digit3, dp_out;
  logic       frame_valid, frame_err, blank;

  always #5 clk = ~clk;

  sevseg_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .blank       (blank)
  );

  // Glyphs as listed for the display (g..a, active-low).
  logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_checks = 0;
  int n_pass   = 0;
  int n_frames = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dpo;
    logic        err;
  } frame_t;

  frame_t     exp_q[$];
  logic [11:0] m_prev;
  bit          m_have_prev;
  int          m_run, m_inv;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_dp, m_mask;
  logic        m_err;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_have_prev = 0; m_mask = 0; m_err = 0; m_inv = 0; m_run = 0;
        exp_q.delete();
      end else begin
        int zeros, idx;
        logic [3:0] nib;
        logic bad;
        if (m_have_prev && {an, seg, dp} == m_prev) m_run++;
        else m_run = 1;
        m_prev = {an, seg, dp};
        m_have_prev = 1;
        zeros = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; idx = i; end
        if (zeros == 1) m_inv = 0;
        else if (m_inv < TIMEOUT) begin
          m_inv++;
          if (m_inv == TIMEOUT) m_mask = 0;
        end
        if (zeros == 1 && m_run == STABLE) begin
          nib = 0; bad = 1;
          for (int i = 0; i < 16; i++) if (seg == pat[i]) begin nib = 4'(i); bad = 0; end
          m_dig[idx]  = nib;
          m_dp[idx]   = !dp;
          m_err       = m_err | bad;
          m_mask[idx] = 1'b1;
          if (m_mask == 4'hF) begin
            exp_q.push_back('{d: {m_dig[3], m_dig[2], m_dig[1], m_dig[0]}, dpo: m_dp,
                              err: m_err});
            m_mask = 0; m_err = 0;
          end
        end
      end
    end
  end

  // Every emitted frame is compared against the model's next expected frame.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_valid === 1'b1) begin
        n_frames++;
        if (exp_q.size() == 0) check("frame_unexpected", frame_valid, 1'b0);
        else check("frame_vs_model", {digit3, digit2, digit1, digit0, dp_out, frame_err},
                   exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an = a; seg = s; dp = d;
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'hF, 7'h7F, 1'b1, 2);
    reset = 1'b0;
  endtask

  task automatic put_digit(input int pos, input int val, input logic dpon, input int n);
    drive(~(4'b0001 << pos), pat[val], !dpon, n);
  endtask

  task automatic wait_frame(input string name, input logic [15:0] d, input logic [3:0] dpo,
                            input logic err);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (frame_valid) seen = 1;
    end
    check({name, "_seen"}, seen, 1'b1);
    check({name, "_digits"}, {digit3, digit2, digit1, digit0}, d);
    check({name, "_dp"}, dp_out, dpo);
    check({name, "_err"}, frame_err, err);
  endtask

  typedef struct {
    logic [6:0] s;
    logic       d;
    logic [3:0] exp_nib;
    logic       exp_dp;
    logic       exp_err;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int f0;
    reset = 1'b1; an = 4'hF; seg = 7'h7F; dp = 1'b1;

    // Reset state
    do_reset();
    check("rst_digits", {digit3, digit2, digit1, digit0}, 16'h0);
    check("rst_dp", dp_out, 4'h0);
    check("rst_err", frame_err, 1'b0);
    check("rst_blank", blank, 1'b0);
    check("rst_fv", frame_valid, 1'b0);

    // Normal frame 1,2,3,4
    put_digit(0, 1, 0, STABLE + 2);
    put_digit(1, 2, 0, STABLE + 2);
    put_digit(2, 3, 0, STABLE + 2);
    put_digit(3, 4, 0, 0);
    wait_frame("normal", 16'h4321, 4'h0, 1'b0);

    // Glitch of '8' shorter than the stability window
    do_reset();
    drive(4'b1110, pat[8], 1'b1, STABLE - 1);
    put_digit(0, 5, 0, STABLE + 2);
    put_digit(1, 6, 0, STABLE + 2);
    drive(4'b1011, pat[8], 1'b1, STABLE - 1);
    put_digit(2, 7, 0, STABLE + 2);
    put_digit(3, 9, 0, 0);
    wait_frame("glitch", 16'h9765, 4'h0, 1'b0);

    // Undecodable pattern with dp on, then a clean frame clears the error
    do_reset();
    put_digit(0, 10, 0, STABLE + 2);
    put_digit(1, 11, 0, STABLE + 2);
    drive(4'b1011, 7'h7F, 1'b0, STABLE + 2);
    put_digit(3, 12, 0, 0);
    wait_frame("bad", 16'hC0BA, 4'b0100, 1'b1);
    put_digit(0, 1, 1, STABLE + 2);
    put_digit(1, 1, 0, STABLE + 2);
    put_digit(2, 1, 0, STABLE + 2);
    put_digit(3, 1, 0, 0);
    wait_frame("after_bad", 16'h1111, 4'b0001, 1'b0);

    // Invalid anode pattern mid-frame
    do_reset();
    put_digit(0, 13, 0, STABLE + 2);
    put_digit(1, 14, 0, STABLE + 2);
    f0 = n_frames;
    drive(4'b1100, pat[3], 1'b0, 50);
    check("inv_no_frame", n_frames, f0);
    put_digit(2, 15, 0, STABLE + 2);
    put_digit(3, 2, 0, 0);
    wait_frame("inv_anode", 16'h2FED, 4'h0, 1'b0);

    // Timeout: blank asserts and partial frame is dropped
    do_reset();
    put_digit(0, 1, 0, STABLE + 2);
    put_digit(1, 2, 0, STABLE + 2);
    drive(4'hF, 7'h7F, 1'b1, TIMEOUT - 10);
    check("blank_early", blank, 1'b0);
    drive(4'hF, 7'h7F, 1'b1, 20);
    check("blank_set", blank, 1'b1);
    f0 = n_frames;
    put_digit(2, 3, 0, STABLE + 2);
    check("blank_clear", blank, 1'b0);
    put_digit(3, 4, 0, STABLE + 4);
    check("timeout_mask_cleared", n_frames, f0);
    put_digit(0, 5, 0, STABLE + 2);
    put_digit(1, 6, 0, 0);
    wait_frame("after_timeout", 16'h4365, 4'h0, 1'b0);

    // Reset after two digits
    do_reset();
    put_digit(0, 7, 0, STABLE + 2);
    put_digit(1, 8, 0, STABLE + 2);
    do_reset();
    f0 = n_frames;
    put_digit(2, 9, 0, STABLE + 2);
    put_digit(3, 10, 0, STABLE + 4);
    check("reset_no_frame", n_frames, f0);
    put_digit(0, 11, 0, STABLE + 2);
    put_digit(1, 12, 0, 0);
    wait_frame("after_reset", 16'hA9CB, 4'h0, 1'b0);

    // Glyph table vectors
    for (int i = 0; i < 16; i++)
      tbl[i] = '{s: pat[i], d: i[0], exp_nib: 4'(i), exp_dp: !i[0], exp_err: 1'b0};
    tbl[16] = '{s: 7'h7F, d: 1'b0, exp_nib: 4'h0, exp_dp: 1'b1, exp_err: 1'b1};
    tbl[17] = '{s: 7'h7E, d: 1'b1, exp_nib: 4'h0, exp_dp: 1'b0, exp_err: 1'b1};
    tbl[18] = '{s: 7'h2A, d: 1'b1, exp_nib: 4'h0, exp_dp: 1'b0, exp_err: 1'b1};
    tbl[19] = '{s: 7'h41, d: 1'b0, exp_nib: 4'h0, exp_dp: 1'b1, exp_err: 1'b1};
    do_reset();
    for (int g = 0; g < 5; g++) begin
      logic [15:0] ed;
      logic [3:0]  edp;
      logic        eerr;
      ed = 0; edp = 0; eerr = 0;
      for (int k = 0; k < 4; k++) begin
        vec_t v;
        v = tbl[g * 4 + k];
        ed[k*4 +: 4] = v.exp_nib;
        edp[k]       = v.exp_dp;
        eerr         = eerr | v.exp_err;
        drive(~(4'b0001 << k), v.s, v.d, (k == 3) ? 0 : STABLE + 2);
      end
      wait_frame($sformatf("table%0d", g), ed, edp, eerr);
    end

    // Randomized traffic against the model
    do_reset();
    begin
      bit last_inv = 0;
      for (int n = 0; n < 400; n++) begin
        logic [3:0] a;
        logic [6:0] s;
        if (!last_inv && $urandom_range(0, 9) < 2) begin
          do a = 4'($urandom); while (a == 4'b1110 || a == 4'b1101 || a == 4'b1011 ||
                                      a == 4'b0111);
          drive(a, 7'($urandom), 1'($urandom), $urandom_range(1, 8));
          last_inv = 1;
        end else begin
          a = ~(4'b0001 << $urandom_range(0, 3));
          s = ($urandom_range(0, 7) < 7) ? pat[$urandom_range(0, 15)] : 7'($urandom);
          drive(a, s, 1'($urandom), $urandom_range(1, STABLE + 3));
          last_inv = 0;
        end
      end
    end
    drive(4'hF, 7'h7F, 1'b1, 20);
    check("model_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
